uart_pkt_tx: RTL
================

# uart_pkt_tx

Host-bound packet transmitter. It arbitrates round-robin among `N_SRC` message sources and frames the winner's message as prefix `0xDD`, address, length, payload, CRC. It serializes every frame byte as 8N1 UART on `tx`. It is the return path to the host, mirroring the host-to-FPGA packet format decoded by the receive side of `bos`.

## Interface
- `N_SRC`, 3: number of message sources.
- `CLKS_PER_BIT`, 417: clocks per UART bit (48 MHz / 115200).
- `ADDR_BASE`, 8'h14: frame address of source 0; source i is sent as `ADDR_BASE+i`.
- `PREFIX`, 8'hDD: frame start byte.
- `clk`  in  1: system clock; everything is rising-edge.
- `rst`  in  1: reset, synchronous, active-high.
- `have_msg_bus`  in  N_SRC: bit i high means source i holds one complete message.
- `len_bus`  in  8*N_SRC: payload length of source i at bits [8i+7:8i]. Stable while `have_msg_bus[i]` is high.
- `data_bus`  in  8*N_SRC: current head byte of source i (show-ahead FIFO).
- `rdreq_bus`  out  N_SRC: one-cycle pop strobe to source i.
- `tx`  out  1: UART line; idles high.
- `busy`  out  1: high from grant until the CRC stop bit ends.

## Operation
- Outputs after reset: `tx`=1, `busy`=0, `rdreq_bus`=0, state IDLE, round-robin pointer = 0.
- States: IDLE → PREFIX → ADDR → LEN → PAYLOAD → CRC → IDLE.
- IDLE: when any `have_msg_bus` bit is high, grant the first set bit at or after the pointer (wrapping).
  - Latch the source index and its length into `cnt`.
  - Set pointer = winner+1 mod N_SRC.
  - Go to PREFIX.
- Each byte state hands one byte to the serializer. On serializer done it advances.
- PREFIX: send `PREFIX`.
- ADDR: send `ADDR_BASE+idx`, modulo 256.
- LEN: send the latched length. If the length is 0, go directly to CRC.
- PAYLOAD: load `data_bus[idx]`, pulse `rdreq_bus[idx]` in the same cycle as the load, and decrement `cnt`. At `cnt`=0 after done, go to CRC.
- CRC: an 8-bit XOR of the address, length and all payload bytes. The prefix is excluded. The CRC register is cleared at grant.
- Changes to `have_msg_bus` during a frame are ignored until IDLE.
- Sources must not drop `have_msg` mid-frame. If one does, the block still sends `len` bytes of whatever `data_bus` shows.
- `rst` mid-frame: immediate return to the reset values. `tx` goes high the next cycle, which may truncate a byte. No further `rdreq`.

## Timing
- Grant registered 1 cycle after `have_msg` is seen in IDLE. The start bit of the prefix begins on `tx` 1 cycle after that.
- Bit order: start(0), d0..d7 LSB first, stop(1). Each bit lasts exactly `CLKS_PER_BIT` cycles.
- No gap between bytes: the next start bit follows the stop bit on the next cycle.
- Frame duration: (4+len)·10·`CLKS_PER_BIT` cycles.
- `rdreq` rules:
  - Exactly one single-cycle pulse per payload byte, coincident with that byte's load.
  - Never asserted for header or CRC bytes.
  - Total `rdreq` pulses per frame = len.
- `busy` falls in the cycle the CRC stop bit completes.
- A new grant can occur on the cycle after that. Back-to-back frames then have a 1-cycle idle high.

## Structure
- Sub-module `uart_tx_byte` holds the serializer.
  - Inputs: `clk`, `rst`, `load`, `din[7:0]`.
  - Outputs: `tx`, `ready`, a `done` pulse.
  - Internals: a bit counter 0..9 and a baud counter 0..`CLKS_PER_BIT`-1.
- `PREFIX`, the state encoding, and the default `ADDR_BASE`/`CLKS_PER_BIT` belong in the shared defines alongside `N_SRC` and `SYS_CLK`.
- Arbiter, framing FSM, CRC and length counter live in `uart_pkt_tx`.

## Test plan
- Reset hold: with `have_msg_bus`=0 for 10000 cycles → `tx`=1, `busy`=0, and no `rdreq`.
- Source 0 with len=2 and bytes 16,1D → bytes on `tx` are DD 14 02 16 1D 1D, where the CRC is 1D. Frame lasts 25020 cycles. Exactly 2 `rdreq_bus[0]` pulses.
- Sources 0 and 2 raised together, len=1 each → source 0 is sent first (addr 14), then source 2 (addr 16). If both are raised again, the next grant goes to source 0 again: source 1 is skipped because it has no message, and the pointer wraps.
- Source 1 with len=0 → DD 15 00 15 and no `rdreq`.
- Source 2 with len=12, bytes 02 01 04 03 … 0C 0B → all 12 bytes are sent in order with 12 pops. The CRC equals the XOR of 16, 0C and the payload.
- `rst` asserted mid-payload → `tx`=1 and `busy`=0 on the next cycle with no further `rdreq`. After release, the next message starts a fresh frame from the prefix.

Source files
------------

// File: rtl/uart_pkt_tx_pkg.sv
// Shared constants and types for the host-bound packet transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the system clock, the default source count, baud divider and frame
// address base, the frame start byte, and the framing FSM state encoding.
package uart_pkt_tx_pkg;

  localparam int SYS_CLK          = 48_000_000;
  localparam int BAUD_RATE        = 115_200;
  localparam int DEF_N_SRC        = 3;
  // 48 MHz / 115200 = 416.67, rounded to the nearest whole clock count.
  localparam int DEF_CLKS_PER_BIT = 417;
  localparam logic [7:0] DEF_ADDR_BASE = 8'h14;
  localparam logic [7:0] DEF_PREFIX    = 8'hDD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFIX,
    ST_ADDR,
    ST_LEN,
    ST_PAYLOAD,
    ST_CRC
  } state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serializer: start bit, d0..d7 LSB first, stop bit.
// Latency: tx drops to the start bit the cycle after load; done marks the last stop-bit cycle.
// Backpressure: ready low while a byte is on the line; a load in the done cycle chains with no gap.
//
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   load, din  accept din when ready or done is high
//   tx         serial line, idles high
//   ready      serializer idle
//   done       one-cycle pulse in the final cycle of the stop bit
module uart_tx_byte
  import uart_pkt_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] din,
  output logic       tx,
  output logic       ready,
  output logic       done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [BAUD_W-1:0] baud_cnt;
  logic [3:0]        bit_cnt;
  // Remaining bits after the start bit: d0..d7 then the stop bit in [8].
  logic [8:0]        shreg;
  logic              active;
  logic              last_baud;

  assign last_baud = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign done      = active && last_baud && (bit_cnt == 4'd9);
  assign ready     = !active;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx       <= 1'b1;
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
    end else if (load) begin
      tx       <= 1'b0;
      shreg    <= {1'b1, din};
      bit_cnt  <= '0;
      baud_cnt <= '0;
      active   <= 1'b1;
    end else if (active) begin
      if (last_baud) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          // Stop bit finished; tx is already high and stays there.
          active <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          tx      <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + BAUD_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_pkt_tx.sv
// Round-robin arbiter + framer: PREFIX, ADDR_BASE+src, len, payload, XOR CRC, each as 8N1 UART.
// Latency: grant registered 1 cycle after have_msg in IDLE; prefix start bit 1 cycle after grant.
// Backpressure: sources are popped (rdreq) only when the serializer takes their byte.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   have_msg_bus   per-source "complete message waiting" flags
//   len_bus        per-source payload length, byte i at [8i+7:8i]
//   data_bus       per-source show-ahead head byte
//   rdreq_bus      per-source one-cycle pop strobe
//   tx             UART line, idles high
//   busy           high from grant until the CRC stop bit ends
module uart_pkt_tx
  import uart_pkt_tx_pkg::*;
#(
  parameter int         N_SRC        = DEF_N_SRC,
  parameter int         CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter logic [7:0] ADDR_BASE    = DEF_ADDR_BASE,
  parameter logic [7:0] PREFIX       = DEF_PREFIX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SRC-1:0]   have_msg_bus,
  input  logic [8*N_SRC-1:0] len_bus,
  input  logic [8*N_SRC-1:0] data_bus,
  output logic [N_SRC-1:0]   rdreq_bus,
  output logic               tx,
  output logic               busy
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic [7:0]       crc, crc_nxt;

  logic             ser_load;
  logic [7:0]       ser_din;
  logic             ser_ready;
  logic             ser_done;

  logic [7:0]       len_arr  [N_SRC];
  logic [7:0]       data_arr [N_SRC];
  logic [7:0]       addr_byte;

  logic             any_req;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] cand;
  int               cand_i;

  for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
    assign len_arr[g]  = len_bus[8*g +: 8];
    assign data_arr[g] = data_bus[8*g +: 8];
  end

  assign addr_byte = ADDR_BASE + 8'(idx);
  assign busy      = (state != ST_IDLE);

  // Round-robin: first requesting source at or after ptr, wrapping.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    cand    = '0;
    cand_i  = 0;
    for (int k = 0; k < N_SRC; k++) begin
      cand_i = int'(ptr) + k;
      if (cand_i >= N_SRC) cand_i = cand_i - N_SRC;
      cand = IDX_W'(cand_i);
      if (!any_req && have_msg_bus[cand]) begin
        any_req = 1'b1;
        win     = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      ptr   <= '0;
      cnt   <= '0;
      crc   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      crc   <= crc_nxt;
    end
  end

  // Each byte state waits for the serializer's done and, in that same cycle,
  // loads the following byte so bytes go out back to back. Only the prefix is
  // loaded from an idle serializer, on the first cycle after the grant.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    crc_nxt   = crc;
    ser_load  = 1'b0;
    ser_din   = '0;
    rdreq_bus = '0;

    case (state)
      ST_IDLE: begin
        if (any_req) begin
          idx_nxt   = win;
          ptr_nxt   = (int'(win) == N_SRC - 1) ? '0 : win + IDX_W'(1);
          cnt_nxt   = len_arr[win];
          crc_nxt   = '0;
          state_nxt = ST_PREFIX;
        end
      end

      ST_PREFIX: begin
        if (ser_ready) begin
          ser_load = 1'b1;
          ser_din  = PREFIX;
        end else if (ser_done) begin
          ser_load  = 1'b1;
          ser_din   = addr_byte;
          crc_nxt   = crc ^ addr_byte;
          state_nxt = ST_ADDR;
        end
      end

      ST_ADDR: begin
        if (ser_done) begin
          // cnt still holds the untouched length here.
          ser_load  = 1'b1;
          ser_din   = cnt;
          crc_nxt   = crc ^ cnt;
          state_nxt = ST_LEN;
        end
      end

      ST_LEN, ST_PAYLOAD: begin
        if (ser_done) begin
          ser_load = 1'b1;
          if (cnt == 8'd0) begin
            ser_din   = crc;
            state_nxt = ST_CRC;
          end else begin
            ser_din         = data_arr[idx];
            rdreq_bus[idx]  = 1'b1;
            crc_nxt         = crc ^ data_arr[idx];
            cnt_nxt         = cnt - 8'd1;
            state_nxt       = ST_PAYLOAD;
          end
        end
      end

      ST_CRC: begin
        if (ser_done) state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase

    // A reset cycle must not pop a source or start a byte.
    if (rst) begin
      ser_load  = 1'b0;
      rdreq_bus = '0;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk  (clk),
    .rst  (rst),
    .load (ser_load),
    .din  (ser_din),
    .tx   (tx),
    .ready(ser_ready),
    .done (ser_done)
  );

endmodule
